// File: rtl/taglist_seq_sched.sv
// Taglist-driven ROM address scheduler: fetches one taglist entry at a time and
// loops its start..end address range until a button press or the auto-advance count.
module taglist_seq_sched #(
    parameter int RAM_LAT = 2,
    parameter int AW      = 10,
    parameter int IW      = 7
) (
    input  logic          clock_p,
    input  logic          reset,
    input  logic          pb_seq_up,
    input  logic          pb_seq_dn,
    input  logic          auto_en,
    input  logic [7:0]    loop_count,
    output logic [IW-1:0] ram_rdaddr,
    input  logic [31:0]   ram_q,
    output logic [AW-1:0] rom_addr,
    output logic          rom_valid,
    output logic [6:0]    seq_id,
    output logic          pass_start
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY} state_t;
    typedef enum logic [1:0] {P_NONE, P_UP, P_DN} pend_t;

    localparam logic [1:0] LAT_LAST = 2'(RAM_LAT - 1);

    state_t        r_state,      w_state_next;
    pend_t         r_pend,       w_pend_next;
    logic [1:0]    r_fetch_cnt,  w_fetch_cnt_next;
    logic [IW-1:0] r_idx,        w_idx_next;
    logic [IW-1:0] r_last_idx,   w_last_idx_next;
    logic          r_last_flag,  w_last_flag_next;
    logic [7:0]    r_loop_cnt,   w_loop_cnt_next;
    logic [AW-1:0] r_start,      w_start_next;
    logic [AW-1:0] r_end,        w_end_next;
    logic [AW-1:0] r_rom_addr,   w_rom_addr_next;
    logic          r_rom_valid,  w_rom_valid_next;
    logic [6:0]    r_seq_id,     w_seq_id_next;
    logic          r_pass_start, w_pass_start_next;
    logic [IW-1:0] r_ram_rdaddr, w_ram_rdaddr_next;

    logic          w_up_only, w_dn_only, w_both;
    logic [IW-1:0] w_idx_up, w_idx_dn;
    logic          w_pass_end;
    logic [8:0]    w_loop_inc;
    logic          w_auto;
    logic          w_go_up, w_go_dn, w_advance;
    logic [IW-1:0] w_adv_idx;

    assign w_up_only  = pb_seq_up & ~pb_seq_dn;
    assign w_dn_only  = pb_seq_dn & ~pb_seq_up;
    assign w_both     = pb_seq_up & pb_seq_dn;
    assign w_idx_up   = r_last_flag ? '0 : r_idx + 1'b1;
    assign w_idx_dn   = (r_idx == '0) ? r_last_idx : r_idx - 1'b1;
    // A reversed range collapses to the single start address, so every cycle ends a pass.
    assign w_pass_end = (r_rom_addr == r_end) || (r_end < r_start);
    assign w_loop_inc = {1'b0, r_loop_cnt} + 9'd1;
    assign w_auto     = auto_en && (loop_count != 8'd0) && (w_loop_inc >= {1'b0, loop_count});

    always_comb begin
        w_state_next      = r_state;
        w_pend_next       = r_pend;
        w_fetch_cnt_next  = r_fetch_cnt;
        w_idx_next        = r_idx;
        w_last_idx_next   = r_last_idx;
        w_last_flag_next  = r_last_flag;
        w_loop_cnt_next   = r_loop_cnt;
        w_start_next      = r_start;
        w_end_next        = r_end;
        w_rom_addr_next   = r_rom_addr;
        w_rom_valid_next  = 1'b0;
        w_seq_id_next     = r_seq_id;
        w_pass_start_next = 1'b0;
        w_ram_rdaddr_next = r_ram_rdaddr;
        w_go_up           = 1'b0;
        w_go_dn           = 1'b0;
        w_advance         = 1'b0;
        w_adv_idx         = r_idx;

        // Outside playback, button pulses are parked in a 1-deep pending slot.
        if (r_state != S_PLAY) begin
            if (w_both)         w_pend_next = P_NONE;
            else if (w_up_only) w_pend_next = P_UP;
            else if (w_dn_only) w_pend_next = P_DN;
        end

        case (r_state)
            S_IDLE: begin
                w_state_next      = S_FETCH;
                w_ram_rdaddr_next = r_idx;
                w_fetch_cnt_next  = 2'd0;
            end
            S_FETCH: begin
                if (r_fetch_cnt == LAT_LAST) w_state_next = S_LOAD;
                else                         w_fetch_cnt_next = r_fetch_cnt + 2'd1;
            end
            S_LOAD: begin
                w_start_next      = ram_q[11 +: AW];
                w_end_next        = ram_q[1 +: AW];
                w_seq_id_next     = ram_q[27:21];
                w_last_flag_next  = ram_q[0];
                if (ram_q[0]) w_last_idx_next = r_idx;
                w_rom_addr_next   = ram_q[11 +: AW];
                w_loop_cnt_next   = 8'd0;
                w_rom_valid_next  = 1'b1;
                w_pass_start_next = 1'b1;
                w_state_next      = S_PLAY;
            end
            default: begin
                w_rom_valid_next = 1'b1;
                if (w_both) begin
                    w_pend_next = P_NONE;
                end else begin
                    w_go_up = w_up_only || (!pb_seq_dn && r_pend == P_UP);
                    w_go_dn = w_dn_only || (!pb_seq_up && r_pend == P_DN);
                end
                if (w_go_up || w_go_dn) begin
                    w_advance = 1'b1;
                    w_adv_idx = w_go_up ? w_idx_up : w_idx_dn;
                end else if (w_pass_end) begin
                    w_loop_cnt_next = (r_loop_cnt == 8'hFF) ? 8'hFF : r_loop_cnt + 8'd1;
                    if (w_auto) begin
                        w_advance = 1'b1;
                        w_adv_idx = w_idx_up;
                    end else begin
                        w_rom_addr_next   = r_start;
                        w_pass_start_next = 1'b1;
                    end
                end else begin
                    w_rom_addr_next = r_rom_addr + 1'b1;
                end
                if (w_advance) begin
                    w_state_next      = S_FETCH;
                    w_idx_next        = w_adv_idx;
                    w_ram_rdaddr_next = w_adv_idx;
                    w_fetch_cnt_next  = 2'd0;
                    w_rom_valid_next  = 1'b0;
                    w_pend_next       = P_NONE;
                end
            end
        endcase
    end

    always_ff @(posedge clock_p) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pend       <= P_NONE;
            r_fetch_cnt  <= 2'd0;
            r_idx        <= '0;
            r_last_idx   <= '0;
            r_last_flag  <= 1'b0;
            r_loop_cnt   <= 8'd0;
            r_start      <= '0;
            r_end        <= '0;
            r_rom_addr   <= '0;
            r_rom_valid  <= 1'b0;
            r_seq_id     <= 7'd0;
            r_pass_start <= 1'b0;
            r_ram_rdaddr <= '0;
        end else begin
            r_state      <= w_state_next;
            r_pend       <= w_pend_next;
            r_fetch_cnt  <= w_fetch_cnt_next;
            r_idx        <= w_idx_next;
            r_last_idx   <= w_last_idx_next;
            r_last_flag  <= w_last_flag_next;
            r_loop_cnt   <= w_loop_cnt_next;
            r_start      <= w_start_next;
            r_end        <= w_end_next;
            r_rom_addr   <= w_rom_addr_next;
            r_rom_valid  <= w_rom_valid_next;
            r_seq_id     <= w_seq_id_next;
            r_pass_start <= w_pass_start_next;
            r_ram_rdaddr <= w_ram_rdaddr_next;
        end
    end

    assign ram_rdaddr = r_ram_rdaddr;
    assign rom_addr   = r_rom_addr;
    assign rom_valid  = r_rom_valid;
    assign seq_id     = r_seq_id;
    assign pass_start = r_pass_start;

endmodule
